// File: rtl/subparser_dispatch.sv
// subparser_dispatch: routes one parser controller to one of NUM_SUBPARSERS subparsers.
//
// A trigger in idle latches sel and starts the chosen subparser once it reports ready.
// While that subparser runs, the single reader path (rd_*/is_empty) is routed to it
// and all other channels see an idle reader. The subparser's done/success is returned
// to the controller as a one-cycle done pulse plus a held success flag.
// An optional watchdog (TIMEOUT_CYCLES > 0) bounds the running phase. On expiry the
// subparser is shown an empty reader so that it winds down by itself.
//
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   trigger, sel                    start request and channel index (sampled in idle)
//   done, rdy, success, timed_out   completion pulse, idle flag, held result flags
//   rd_trigger, rd_done, rd_rdy,
//   is_empty                        shared reader interface
//   sp_trigger, sp_done, sp_rdy,
//   sp_success                      per-channel subparser control
//   sp_rd_trigger, sp_rd_done,
//   sp_rd_rdy, sp_is_empty          per-channel reader interface
module subparser_dispatch #(
    parameter int unsigned NUM_SUBPARSERS = 4,
    parameter int unsigned SEL_WIDTH      = $clog2(NUM_SUBPARSERS),
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      trigger,
    input  logic [SEL_WIDTH-1:0]      sel,
    output logic                      done,
    output logic                      rdy,
    output logic                      success,
    output logic                      timed_out,
    output logic                      rd_trigger,
    input  logic                      rd_done,
    input  logic                      rd_rdy,
    input  logic                      is_empty,
    output logic [NUM_SUBPARSERS-1:0] sp_trigger,
    input  logic [NUM_SUBPARSERS-1:0] sp_done,
    input  logic [NUM_SUBPARSERS-1:0] sp_rdy,
    input  logic [NUM_SUBPARSERS-1:0] sp_rd_trigger,
    output logic [NUM_SUBPARSERS-1:0] sp_rd_done,
    output logic [NUM_SUBPARSERS-1:0] sp_rd_rdy,
    output logic [NUM_SUBPARSERS-1:0] sp_is_empty,
    input  logic [NUM_SUBPARSERS-1:0] sp_success
);

    localparam int unsigned CntW =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TimeoutLast =
        (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [SEL_WIDTH:0] NumSp = (SEL_WIDTH + 1)'(NUM_SUBPARSERS);
    localparam logic [CntW-1:0]    CntMax = {CntW{1'b1}};
    localparam logic [CntW-1:0]    CntLast = CntW'(TimeoutLast);

    typedef enum logic [2:0] {
        StIdle,
        StWaitRdy,
        StBusy,
        StDrain,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic                 success_q, success_d;
    logic                 timed_out_q, timed_out_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    logic sel_ok;
    logic expire;

    // Non-power-of-two channel counts leave sel codes with no subparser behind them.
    assign sel_ok = ({1'b0, sel} < NumSp);
    assign expire = (TIMEOUT_CYCLES > 0) && (cnt_q == CntLast);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            success_q   <= 1'b0;
            timed_out_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            success_q   <= success_d;
            timed_out_q <= timed_out_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        success_d   = success_q;
        timed_out_d = timed_out_q;
        cnt_d       = cnt_q;

        // Idle reader presented to every channel unless routing says otherwise.
        rd_trigger  = 1'b0;
        sp_trigger  = '0;
        sp_rd_done  = '0;
        sp_rd_rdy   = '0;
        sp_is_empty = '1;

        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    success_d = 1'b0;
                    if (sel_ok) begin
                        sel_d       = sel;
                        timed_out_d = 1'b0;
                        state_d     = StWaitRdy;
                    end else begin
                        timed_out_d = 1'b1;
                        state_d     = StDone;
                    end
                end
            end

            StWaitRdy: begin
                sp_trigger[sel_q] = sp_rdy[sel_q];
                if (sp_rdy[sel_q]) begin
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end

            StBusy: begin
                rd_trigger         = sp_rd_trigger[sel_q];
                sp_rd_done[sel_q]  = rd_done;
                sp_rd_rdy[sel_q]   = rd_rdy;
                sp_is_empty[sel_q] = is_empty;
                // A done on the expiry cycle takes priority over the watchdog.
                if (sp_done[sel_q]) begin
                    success_d = sp_success[sel_q];
                    state_d   = StDone;
                end else begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                    if (expire) begin
                        timed_out_d = 1'b1;
                        state_d     = StDrain;
                    end
                end
            end

            // Reader stays idle/empty (the defaults) until the subparser gives up.
            StDrain: begin
                if (sp_done[sel_q]) begin
                    success_d = 1'b0;
                    state_d   = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign done      = (state_q == StDone);
    assign rdy       = (state_q == StIdle);
    assign success   = success_q;
    assign timed_out = timed_out_q;

endmodule

// File: tb/tb_subparser_dispatch.sv
// Bench for subparser_dispatch: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_subparser_dispatch;

    localparam int NUM = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 4 channels, watchdog of 8 cycles
    logic       reset, trigger;
    logic [1:0] sel;
    logic       done, rdy, success, timed_out;
    logic       rd_trigger, rd_done, rd_rdy, is_empty;
    logic [3:0] sp_trigger, sp_done, sp_rdy, sp_rd_trigger;
    logic [3:0] sp_rd_done, sp_rd_rdy, sp_is_empty, sp_success;

    // DUT B: 3 channels, watchdog disabled
    logic       b_reset, b_trigger;
    logic [1:0] b_sel;
    logic       b_done, b_rdy, b_success, b_timed_out;
    logic       b_rd_trigger, b_rd_done, b_rd_rdy, b_is_empty;
    logic [2:0] b_sp_trigger, b_sp_done, b_sp_rdy, b_sp_rd_trigger;
    logic [2:0] b_sp_rd_done, b_sp_rd_rdy, b_sp_is_empty, b_sp_success;

    subparser_dispatch #(.NUM_SUBPARSERS(4), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .reset(reset), .trigger(trigger), .sel(sel),
        .done(done), .rdy(rdy), .success(success), .timed_out(timed_out),
        .rd_trigger(rd_trigger), .rd_done(rd_done), .rd_rdy(rd_rdy), .is_empty(is_empty),
        .sp_trigger(sp_trigger), .sp_done(sp_done), .sp_rdy(sp_rdy),
        .sp_rd_trigger(sp_rd_trigger), .sp_rd_done(sp_rd_done), .sp_rd_rdy(sp_rd_rdy),
        .sp_is_empty(sp_is_empty), .sp_success(sp_success)
    );

    subparser_dispatch #(.NUM_SUBPARSERS(3), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .reset(b_reset), .trigger(b_trigger), .sel(b_sel),
        .done(b_done), .rdy(b_rdy), .success(b_success), .timed_out(b_timed_out),
        .rd_trigger(b_rd_trigger), .rd_done(b_rd_done), .rd_rdy(b_rd_rdy),
        .is_empty(b_is_empty),
        .sp_trigger(b_sp_trigger), .sp_done(b_sp_done), .sp_rdy(b_sp_rdy),
        .sp_rd_trigger(b_sp_rd_trigger), .sp_rd_done(b_sp_rd_done),
        .sp_rd_rdy(b_sp_rd_rdy), .sp_is_empty(b_sp_is_empty), .sp_success(b_sp_success)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        trigger = 0; sel = 0; sp_done = 0; sp_rdy = 0; sp_rd_trigger = 0;
        sp_success = 0; rd_done = 0; rd_rdy = 0; is_empty = 1;
    endtask

    // Transaction-level model of DUT A: a parse is either pending a ready subparser,
    // running (busy_n cycles elapsed) or expired (busy_n reached TMO), then one done cycle.
    bit m_in_parse, m_started, m_fin, m_succ, m_to;
    int m_busy_n, m_sel;

    always @(posedge clk) begin
        if (!reset) begin
            m_in_parse <= 0; m_started <= 0; m_fin <= 0; m_succ <= 0; m_to <= 0;
            m_busy_n <= 0; m_sel <= 0;
        end else if (m_fin) begin
            m_fin <= 0;
        end else if (!m_in_parse) begin
            if (trigger) begin
                m_succ <= 0;
                if (int'(sel) < NUM) begin
                    m_in_parse <= 1; m_started <= 0; m_sel <= int'(sel); m_to <= 0;
                end else begin
                    m_fin <= 1; m_to <= 1;
                end
            end
        end else if (!m_started) begin
            if (sp_rdy[m_sel]) begin
                m_started <= 1; m_busy_n <= 0;
            end
        end else if (sp_done[m_sel]) begin
            m_succ     <= (m_busy_n >= TMO) ? 1'b0 : sp_success[m_sel];
            m_in_parse <= 0;
            m_fin      <= 1;
        end else if (m_busy_n < TMO) begin
            m_busy_n <= m_busy_n + 1;
            if (m_busy_n + 1 == TMO) m_to <= 1;
        end
    end

    always @(negedge clk) begin
        automatic bit       expired, routing;
        automatic logic [3:0] e_trig, e_empty, e_rrdy, e_rdone;
        automatic logic     e_rdtrig;
        if (chk_en && reset) begin
            expired  = m_started && (m_busy_n >= TMO);
            routing  = m_in_parse && m_started && !expired;
            e_trig   = (m_in_parse && !m_started && sp_rdy[m_sel]) ? 4'(1 << m_sel) : 4'h0;
            e_empty  = 4'hf;
            e_rrdy   = 4'h0;
            e_rdone  = 4'h0;
            e_rdtrig = 1'b0;
            if (routing) begin
                e_empty[m_sel] = is_empty;
                e_rrdy[m_sel]  = rd_rdy;
                e_rdone[m_sel] = rd_done;
                e_rdtrig       = sp_rd_trigger[m_sel];
            end
            check("model.rdy", rdy, !m_in_parse && !m_fin);
            check("model.done", done, m_fin);
            check("model.success", success, m_succ);
            check("model.timed_out", timed_out, m_to);
            check("model.sp_trigger", sp_trigger, e_trig);
            check("model.sp_is_empty", sp_is_empty, e_empty);
            check("model.sp_rd_rdy", sp_rd_rdy, e_rrdy);
            check("model.sp_rd_done", sp_rd_done, e_rdone);
            check("model.rd_trigger", rd_trigger, e_rdtrig);
        end
    end

    initial begin
        reset = 0; idle_a();
        b_reset = 0; b_trigger = 0; b_sel = 0; b_sp_done = 0; b_sp_rdy = 0;
        b_sp_rd_trigger = 0; b_sp_success = 0; b_rd_done = 0; b_rd_rdy = 0; b_is_empty = 1;
        tick(); tick();
        reset = 1; b_reset = 1;
        #2;
        check("reset.rdy", rdy, 1); check("reset.done", done, 0);
        check("reset.success", success, 0); check("reset.timed_out", timed_out, 0);
        check("reset.sp_trigger", sp_trigger, 4'b0000);
        check("reset.sp_is_empty", sp_is_empty, 4'b1111);
        chk_en = 1;
        tick();

        // Normal parse on channel 2 with two routed reads
        trigger = 1; sel = 2; sp_rdy = 4'b1111; tick();
        trigger = 0; #2; check("sel2.sp_trigger", sp_trigger, 4'b0100); tick();
        sp_rd_trigger = 4'b0100; rd_rdy = 1; #2;
        check("sel2.rd_trigger", rd_trigger, 1); check("sel2.sp_rd_rdy", sp_rd_rdy, 4'b0100);
        tick();
        sp_rd_trigger = 0; rd_done = 1; #2;
        check("sel2.sp_rd_done", sp_rd_done, 4'b0100); check("sel2.rd_trig_low", rd_trigger, 0);
        tick();
        sp_rd_trigger = 4'b0100; rd_done = 0; #2; check("sel2.rd_trigger2", rd_trigger, 1);
        tick();
        sp_rd_trigger = 0; rd_done = 1; #2; check("sel2.sp_rd_done2", sp_rd_done, 4'b0100);
        tick();
        rd_done = 0; sp_done = 4'b0100; sp_success = 4'b0100; #2;
        check("sel2.done_early", done, 0);
        tick();
        sp_done = 0; #2;
        check("sel2.done", done, 1); check("sel2.success", success, 1);
        check("sel2.timed_out", timed_out, 0);
        tick();
        #2; check("sel2.back_idle", rdy, 1); check("sel2.done_once", done, 0);
        idle_a(); tick();

        // Channel 1 not ready for 5 cycles; foreign read request ignored
        trigger = 1; sel = 1; tick();
        trigger = 0; sp_rd_trigger = 4'b0001; rd_rdy = 1;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("wait.sp_trigger", sp_trigger, 4'b0000); check("wait.rdy", rdy, 0);
            check("wait.rd_trigger", rd_trigger, 0);
            tick();
        end
        sp_rdy = 4'b0010; #2; check("wait.sp_trigger_rise", sp_trigger, 4'b0010); tick();
        #2; check("wait.foreign_rd", rd_trigger, 0);
        sp_done = 4'b0010; sp_success = 4'b0000; tick();
        sp_done = 0; #2;
        check("wait.done", done, 1); check("wait.success", success, 0);
        check("wait.timed_out", timed_out, 0);
        idle_a(); tick();

        // Watchdog expiry on channel 3
        trigger = 1; sel = 3; sp_rdy = 4'b1111; tick();
        trigger = 0; is_empty = 0; rd_rdy = 1; tick();
        for (int i = 0; i < TMO; i++) begin
            #2;
            check("tmo.busy_empty", sp_is_empty, 4'b0111);
            check("tmo.busy_rrdy", sp_rd_rdy, 4'b1000);
            tick();
        end
        sp_rd_trigger = 4'b1000; #2;
        check("tmo.drain_empty", sp_is_empty, 4'b1111); check("tmo.drain_rrdy", sp_rd_rdy, 0);
        check("tmo.drain_rdtrig", rd_trigger, 0); check("tmo.drain_flag", timed_out, 1);
        tick();
        sp_done = 4'b1000; sp_success = 4'b1000; #2; check("tmo.no_done_yet", done, 0);
        tick();
        sp_done = 0; #2;
        check("tmo.done", done, 1); check("tmo.success", success, 0);
        check("tmo.timed_out", timed_out, 1);
        idle_a(); tick();

        // Done on the exact expiry cycle wins over the watchdog
        trigger = 1; sel = 0; sp_rdy = 4'b1111; tick();
        trigger = 0; tick();
        repeat (TMO - 1) tick();
        sp_done = 4'b0001; sp_success = 4'b0001; tick();
        sp_done = 0; #2;
        check("edge.done", done, 1); check("edge.success", success, 1);
        check("edge.timed_out", timed_out, 0);
        idle_a(); tick();

        // DUT B: out-of-range sel, watchdog disabled, reset mid-parse
        b_trigger = 1; b_sel = 3; #2; check("b.bad_sp_trigger0", b_sp_trigger, 0); tick();
        b_trigger = 0; #2;
        check("b.bad_done", b_done, 1); check("b.bad_success", b_success, 0);
        check("b.bad_timed_out", b_timed_out, 1); check("b.bad_sp_trigger", b_sp_trigger, 0);
        tick();
        #2; check("b.bad_done_once", b_done, 0); check("b.bad_rdy", b_rdy, 1);
        b_trigger = 1; b_sel = 2; b_sp_rdy = 3'b111; tick();
        b_trigger = 0; #2; check("b.sp_trigger", b_sp_trigger, 3'b100);
        check("b.cleared_to", b_timed_out, 0); tick();
        b_is_empty = 0;
        for (int i = 0; i < 20; i++) begin
            #2; check("b.no_watchdog", b_sp_is_empty, 3'b011); tick();
        end
        b_reset = 0; tick();
        b_reset = 1; #2;
        check("b.rst_rdy", b_rdy, 1); check("b.rst_done", b_done, 0);
        check("b.rst_sp_trigger", b_sp_trigger, 0); check("b.rst_empty", b_sp_is_empty, 3'b111);
        tick();
        #2; check("b.rst_no_done", b_done, 0);

        // Randomized traffic on DUT A, including occasional resets and foreign activity
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 299) != 0);
            trigger       = ($urandom_range(0, 2) == 0);
            sel           = 2'($urandom);
            sp_rdy        = 4'($urandom);
            sp_done       = 4'($urandom) & 4'($urandom) & 4'($urandom);
            sp_success    = 4'($urandom);
            sp_rd_trigger = 4'($urandom);
            rd_done       = 1'($urandom);
            rd_rdy        = 1'($urandom);
            is_empty      = 1'($urandom);
            tick();
        end
        reset = 1; idle_a();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
